ula_result_stage: RTL
=====================

Name: ula_result_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Captures each ALU result, its flags and its instruction context behind a valid/ready handshake.
- Keeps the architectural condition-code register and resolves beq/bne/jump into a registered branch request for the fetch stage.
- Uses a 2-entry skid buffer so writeback backpressure never drops an ALU result.

Parameters:
- RD_W, 5, destination register index width
- PC_W, 32, program-counter and branch-target width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept this cycle
- in_opcode  in  5  ALU opcode of the instruction
- in_result  in  32  ALU Out
- in_zero, in_neg, in_carry, in_overflow  in  1 each  ALU flags
- in_rd  in  RD_W  destination register
- in_wen  in  1  instruction writes a register
- in_target  in  PC_W  precomputed branch/jump target
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback consumes the entry
- out_result  out  32  registered result
- out_rd  out  RD_W  registered destination
- out_wen  out  1  registered write enable
- flags_q  out  4  condition codes {N,Z,C,V}
- branch_taken  out  1  one-cycle taken pulse
- branch_target  out  PC_W  target, valid while branch_taken=1

Behaviour:
- Reset is asynchronous, active-low, and may assert at any time, including mid-stall.
- Reset values: out_valid=0, out_result=0, out_rd=0, out_wen=0, flags_q=0, branch_taken=0, branch_target=0, in_ready=1. Both buffer entries are invalidated and any pending pulse is dropped.
- Accept: the cycle where in_valid && in_ready.
- Storage: an output register plus one skid register.
  - Accepted data goes to the output register if it is empty or out_ready=1 that cycle; otherwise it goes to the skid register.
  - in_ready = !skid_valid, registered, so it falls the cycle after the skid fills.
- Pop: out_valid && out_ready.
  - On a pop, skid data (if any) moves to the output register and skid_valid clears.
  - A simultaneous accept lands in the output register when the skid is empty, otherwise in the skid.
- Order: strict FIFO; no entry is ever lost or duplicated.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- out_valid holds, and outputs stay stable, until popped.
- Branch opcodes (00010 beq, 00111 bne, 01010 jump):
  - Forced out_wen=0; the result is don't-care.
  - beq/bne: taken if in_zero=1, since the ALU sets zero=1 when the compare condition holds.
  - jump: always taken.
  - On accept of a taken branch: branch_taken=1 for exactly the next cycle, with branch_target=in_target. Resolution happens at accept, independent of writeback stalls.
  - Back-to-back taken branches give two consecutive pulses, each with its own target.
- Flag update, on accept only, flags_q <= {in_neg,in_zero,in_carry,in_overflow} for these opcodes:
  - 00000, 00001: flags_q.C <= in_carry; C is cleared only by ops that define C=0.
  - 00011, 00101, 00110, 01000, 10000, 10011, 10101, 10110, 10111, 11000, 11001, 11010, 11011, 11100, 11101, 11110, 11111.
- flags_q holds for: 00100, 01001, 10001, 10010, 10100, 01011, 01100, the branch opcodes, and any unlisted opcode.
- No flag or branch effect without an accept.

Optional Feature:
- Macro ULA_RESULT_STAGE_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count, 32 bits, reset 0.
  - Increments by 1 per pop, wraps 0xFFFFFFFF -> 0.
  - Pop and reset in the same cycle: reset wins.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then accept opcode 00000, result 0x00000005, rd=3, wen=1, zero=0, with out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_wen=1, flags_q=0000.
2. out_ready=0 while accepting results 0xA, then 0xB -> in_ready=0 after 2nd accept; 3rd in_valid held. Raise out_ready -> pops 0xA then 0xB in order, in_ready returns to 1, no loss.
3. beq with in_zero=1, in_target=0x40, then bne with in_zero=0 -> single branch_taken pulse with target 0x40 the cycle after beq accept; no pulse for bne; out_wen=0 for both.
4. Opcode 00101 with neg=1, overflow=1, then opcode 10001 with zero=1 -> flags_q=1001 and stays 1001 after the AND.
5. Fill both buffer entries and pulse reset low mid-stall -> out_valid=0, in_ready=1, flags_q=0 immediately, without waiting for a clock edge.
6. With ULA_RESULT_STAGE_RETIRE_CNT_EN defined: 3 pops -> retire_count=3. Preload 0xFFFFFFFF, then 1 pop -> 0.

Source files
------------

// File: rtl/ula_result_stage.sv
// ALU result stage: 2-entry skid buffer toward writeback, condition-code register, branch resolve.
// Optional retire counter enabled by defining ULA_RESULT_STAGE_RETIRE_CNT_EN.
module ula_result_stage #(
    parameter int unsigned RD_W = 5,
    parameter int unsigned PC_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_opcode,
    input  logic [31:0]     in_result,
    input  logic            in_zero,
    input  logic            in_neg,
    input  logic            in_carry,
    input  logic            in_overflow,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_wen,
    input  logic [PC_W-1:0] in_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic [3:0]      flags_q,
    output logic            branch_taken,
    output logic [PC_W-1:0] branch_target
`ifdef ULA_RESULT_STAGE_RETIRE_CNT_EN
    , output logic [31:0]   retire_count
`endif
);

    localparam logic [4:0] OpBeq  = 5'b00010;
    localparam logic [4:0] OpBne  = 5'b00111;
    localparam logic [4:0] OpJump = 5'b01010;

    typedef struct packed {
        logic [31:0]     result;
        logic [RD_W-1:0] rd;
        logic            wen;
    } entry_t;

    entry_t          in_entry;
    entry_t          out_q, out_d;
    entry_t          skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            accept, pop;
    logic            is_branch, taken, flag_upd;
    logic [3:0]      flags_d;
    logic            branch_taken_q;
    logic [PC_W-1:0] branch_target_q;

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid_q & out_ready;
    assign is_branch = (in_opcode == OpBeq) | (in_opcode == OpBne) | (in_opcode == OpJump);
    // The ALU raises zero when the compare condition holds, for both beq and bne.
    assign taken     = accept & ((in_opcode == OpJump) |
                                 (((in_opcode == OpBeq) | (in_opcode == OpBne)) & in_zero));

    always_comb begin
        in_entry.result = in_result;
        in_entry.rd     = in_rd;
        in_entry.wen    = in_wen & ~is_branch;
    end

    always_comb begin
        flag_upd = 1'b0;
        case (in_opcode)
            5'b00000, 5'b00001, 5'b00011, 5'b00101, 5'b00110, 5'b01000,
            5'b10000, 5'b10011, 5'b10101, 5'b10110, 5'b10111,
            5'b11000, 5'b11001, 5'b11010, 5'b11011,
            5'b11100, 5'b11101, 5'b11110, 5'b11111: flag_upd = 1'b1;
            default:                                flag_upd = 1'b0;
        endcase
    end

    assign flags_d = (accept && flag_upd) ? {in_neg, in_zero, in_carry, in_overflow} : flags_q;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            if (skid_valid_q) begin
                out_d = skid_q;
                if (accept) begin
                    skid_d = in_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                out_d = in_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q           <= '0;
            skid_q          <= '0;
            out_valid_q     <= 1'b0;
            skid_valid_q    <= 1'b0;
            flags_q         <= 4'b0000;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            out_q           <= out_d;
            skid_q          <= skid_d;
            out_valid_q     <= out_valid_d;
            skid_valid_q    <= skid_valid_d;
            flags_q         <= flags_d;
            branch_taken_q  <= taken;
            if (taken) begin
                branch_target_q <= in_target;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_q.result;
    assign out_rd        = out_q.rd;
    assign out_wen       = out_q.wen;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;

`ifdef ULA_RESULT_STAGE_RETIRE_CNT_EN
    logic [31:0] retire_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count_q <= 32'd0;
        end else if (pop) begin
            retire_count_q <= retire_count_q + 32'd1;
        end
    end

    assign retire_count = retire_count_q;
`endif

endmodule
